// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control sequencer: ALU control codes,
// MIPS opcode/funct field values and the sequencer state type.
package alu_pkg;

  typedef enum logic [2:0] {
    CTRL_ADD = 3'b000,
    CTRL_SUB = 3'b001,
    CTRL_AND = 3'b010,
    CTRL_OR  = 3'b011
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bus of the ALU control sequencer. The master is the
// requester; the slave is the sequencer.
interface alu_ctrl_seq_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req_valid, opcode, funct, a_in, b_in, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, opcode, funct, a_in, b_in, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational opcode/funct decoder producing the ALU control code.
// Set-less-than (funct 101010) is legal only when ALU_CTRL_SEQ_SLT_EN is defined.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_e      ctrl,
  output logic       legal,
  output logic       is_slt
);

  always_comb begin
    ctrl   = CTRL_ADD;
    legal  = 1'b0;
    is_slt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin ctrl = CTRL_ADD; legal = 1'b1; end
          FN_SUB: begin ctrl = CTRL_SUB; legal = 1'b1; end
          FN_AND: begin ctrl = CTRL_AND; legal = 1'b1; end
          FN_OR:  begin ctrl = CTRL_OR;  legal = 1'b1; end
`ifdef ALU_CTRL_SEQ_SLT_EN
          FN_SLT: begin ctrl = CTRL_SUB; legal = 1'b1; is_slt = 1'b1; end
`endif
          default: ;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin ctrl = CTRL_ADD; legal = 1'b1; end
      OP_ANDI:               begin ctrl = CTRL_AND; legal = 1'b1; end
      OP_ORI:                begin ctrl = CTRL_OR;  legal = 1'b1; end
      OP_BEQ:                begin ctrl = CTRL_SUB; legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequencer that decodes a MIPS-style op, drives an external ALU for one
// cycle and returns the result over a valid/ready response. Optional slt via ALU_CTRL_SEQ_SLT_EN.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_ctrl_seq_if.slave    bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_q
);

  state_e           state, state_nxt;
  logic             accept;
  ctrl_e            dec_ctrl;
  logic             dec_legal;
  logic             dec_slt;

  logic [WIDTH-1:0] a_p0, b_p0;
  ctrl_e            ctrl_p0;
  logic             slt_p0;
  logic [WIDTH-1:0] rsp_data_p1;
  logic             rsp_zero_p1;
  logic             rsp_err_p1;
  logic [WIDTH-1:0] exec_res;

  // slt is the sign of a-b corrected for signed overflow of the subtraction
  function automatic logic slt_bit(input logic a_msb, input logic b_msb,
                                   input logic q_msb);
    logic ovf;
    ovf = (a_msb != b_msb) && (q_msb != a_msb);
    return q_msb ^ ovf;
  endfunction

  function automatic logic [WIDTH-1:0] exec_result(input logic slt,
                                                   input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] q);
    if (slt)
      return {{(WIDTH-1){1'b0}}, slt_bit(a[WIDTH-1], b[WIDTH-1], q[WIDTH-1])};
    return q;
  endfunction

  alu_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .ctrl   (dec_ctrl),
    .legal  (dec_legal),
    .is_slt (dec_slt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = dec_legal ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);

  assign exec_res = exec_result(slt_p0, a_p0, b_p0, alu_q);

  // p0: operands/ctrl captured at accept; only legal ops touch the ALU drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0    <= '0;
      b_p0    <= '0;
      ctrl_p0 <= CTRL_ADD;
      slt_p0  <= 1'b0;
    end else if (accept && dec_legal) begin
      a_p0    <= bus.a_in;
      b_p0    <= bus.b_in;
      ctrl_p0 <= dec_ctrl;
      slt_p0  <= dec_slt;
    end
  end

  // p1: response captured at end of EXEC, or forced error on an illegal accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_p1 <= '0;
      rsp_zero_p1 <= 1'b0;
      rsp_err_p1  <= 1'b0;
    end else if (accept && !dec_legal) begin
      rsp_data_p1 <= '0;
      rsp_zero_p1 <= 1'b1;
      rsp_err_p1  <= 1'b1;
    end else if (state == ST_EXEC) begin
      rsp_data_p1 <= exec_res;
      rsp_zero_p1 <= (exec_res == '0);
      rsp_err_p1  <= 1'b0;
    end
  end

  assign alu_a        = a_p0;
  assign alu_b        = b_p0;
  assign alu_ctrl     = ctrl_p0;
  assign bus.rsp_data = rsp_data_p1;
  assign bus.rsp_zero = rsp_zero_p1;
  assign bus.rsp_err  = rsp_err_p1;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with a behavioural external ALU.
// Expectations for funct 101010 follow ALU_CTRL_SEQ_SLT_EN.
module tb_alu_ctrl_seq;

  localparam int W = 32;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        zero;
    logic        err;
    logic [2:0]  ctrl;
    int          lat;
  } vec_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] alu_a, alu_b, alu_q;
  logic [2:0]   alu_ctrl;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_a = '0, last_b = '0;
  logic [2:0]  last_ctrl = '0;

  alu_ctrl_seq_if #(.WIDTH(W)) ifc ();

  alu_ctrl_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifc),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_q    (alu_q)
  );

  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_q = alu_a + alu_b;
      3'b001:  alu_q = alu_a + ~alu_b + 32'd1;
      3'b010:  alu_q = alu_a & alu_b;
      3'b011:  alu_q = alu_a | alu_b;
      default: alu_q = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(ifc.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(ifc.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  ifc.rsp_data,       32'd0);
    chk({tag, "_rsp_zero"},  32'(ifc.rsp_zero),  32'd0);
    chk({tag, "_rsp_err"},   32'(ifc.rsp_err),   32'd0);
    chk({tag, "_alu_a"},     alu_a,              32'd0);
    chk({tag, "_alu_b"},     alu_b,              32'd0);
    chk({tag, "_alu_ctrl"},  32'(alu_ctrl),      32'd0);
  endtask

  task automatic drive_req(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
    ifc.req_valid = 1'b1;
    ifc.opcode    = op;
    ifc.funct     = fn;
    ifc.a_in      = a;
    ifc.b_in      = b;
  endtask

  task automatic handshake(input string tag);
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    chk({tag, "_post_rsp_valid"}, 32'(ifc.rsp_valid), 32'd0);
    chk({tag, "_post_req_ready"}, 32'(ifc.req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    g;
    int    lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    drive_req(v.op, v.fn, v.a, v.b);
    g = 0;
    while (!ifc.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_req_ready"}, 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    if (!v.err) begin
      chk({tag, "_exec_ctrl"}, 32'(alu_ctrl), 32'(v.ctrl));
      chk({tag, "_exec_a"},    alu_a,         v.a);
      chk({tag, "_exec_b"},    alu_b,         v.b);
      last_a = v.a; last_b = v.b; last_ctrl = v.ctrl;
    end else begin
      chk({tag, "_hold_ctrl"}, 32'(alu_ctrl), 32'(last_ctrl));
      chk({tag, "_hold_a"},    alu_a,         last_a);
      chk({tag, "_hold_b"},    alu_b,         last_b);
    end
    lat = 1;
    while (!ifc.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"},  32'(lat),          32'(v.lat));
    chk({tag, "_rsp_data"}, ifc.rsp_data,      v.data);
    chk({tag, "_rsp_zero"}, 32'(ifc.rsp_zero), 32'(v.zero));
    chk({tag, "_rsp_err"},  32'(ifc.rsp_err),  32'(v.err));
    handshake(tag);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 3'd0, 2};
    vecs[1]  = '{6'h04, 6'h00, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0, 3'd1, 2};
    vecs[2]  = '{6'h00, 6'h22, 32'd10,       32'd3,        32'd7,        1'b0, 1'b0, 3'd1, 2};
    vecs[3]  = '{6'h00, 6'h24, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 3'd2, 2};
    vecs[4]  = '{6'h00, 6'h25, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b0, 1'b0, 3'd3, 2};
    vecs[5]  = '{6'h08, 6'h3F, 32'd100,      32'hFFFFFFFF, 32'd99,       1'b0, 1'b0, 3'd0, 2};
    vecs[6]  = '{6'h23, 6'h00, 32'h1000,     32'h20,       32'h1020,     1'b0, 1'b0, 3'd0, 2};
    vecs[7]  = '{6'h3F, 6'h20, 32'd1,        32'd2,        32'd0,        1'b1, 1'b1, 3'd0, 1};
    vecs[8]  = '{6'h2B, 6'h00, 32'h2000,     32'd4,        32'h2004,     1'b0, 1'b0, 3'd0, 2};
    vecs[9]  = '{6'h0C, 6'h00, 32'hFF,       32'h0F,       32'h0F,       1'b0, 1'b0, 3'd2, 2};
    vecs[10] = '{6'h0D, 6'h00, 32'hA0,       32'h05,       32'hA5,       1'b0, 1'b0, 3'd3, 2};
    vecs[11] = '{6'h00, 6'h00, 32'd3,        32'd4,        32'd0,        1'b1, 1'b1, 3'd0, 1};
    vecs[12] = '{6'h00, 6'h20, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 3'd0, 2};
`ifdef ALU_CTRL_SEQ_SLT_EN
    vecs[13] = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 3'd1, 2};
    vecs[14] = '{6'h00, 6'h2A, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b0, 3'd1, 2};
`else
    vecs[13] = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 3'd0, 1};
    vecs[14] = '{6'h00, 6'h2A, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b1, 3'd0, 1};
`endif

    reset = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.opcode    = '0;
    ifc.funct     = '0;
    ifc.a_in      = '0;
    ifc.b_in      = '0;
    ifc.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Backpressure: response held while a second request waits
    drive_req(6'h00, 6'h20, 32'd1, 32'd2);
    @(posedge clk);
    @(negedge clk);
    drive_req(6'h00, 6'h22, 32'd9, 32'd4);
    chk("bp_exec_req_ready", 32'(ifc.req_ready), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_rsp_valid", c), 32'(ifc.rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rsp_data", c),  ifc.rsp_data,       32'd3);
      chk($sformatf("bp%0d_req_ready", c), 32'(ifc.req_ready), 32'd0);
      chk($sformatf("bp%0d_alu_a", c),     alu_a,              32'd1);
      @(negedge clk);
    end
    handshake("bp1");
    @(posedge clk);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    chk("bp2_exec_a",    alu_a,               32'd9);
    chk("bp2_exec_ctrl", 32'(alu_ctrl),       32'd1);
    chk("bp2_rsp_valid", 32'(ifc.rsp_valid),  32'd0);
    @(negedge clk);
    chk("bp2_rsp_valid_resp", 32'(ifc.rsp_valid), 32'd1);
    chk("bp2_rsp_data",       ifc.rsp_data,       32'd5);
    handshake("bp2");
    last_a = 32'd9; last_b = 32'd4; last_ctrl = 3'd1;

    // Reset asserted mid-EXEC acts without a clock edge
    drive_req(6'h00, 6'h24, 32'hFF, 32'h0F);
    @(posedge clk);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    chk("re_exec_a", alu_a, 32'hFF);
    reset = 1'b1;
    #1;
    chk_reset_vals("re");
    @(negedge clk);
    reset = 1'b0;
    last_a = '0; last_b = '0; last_ctrl = '0;
    @(negedge clk);
    run_vec(vecs[0], 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
